// File: rtl/weight_buf_pkg.sv
// Shared types and defaults for the ping-pong weight buffer.
// Bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
package weight_buf_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_DEPTH  = 256;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic logic bank_writable(input bank_state_t s);
    return (s == EMPTY) || (s == FILLING);
  endfunction

  function automatic logic bank_readable(input bank_state_t s);
    return (s == FULL) || (s == DRAINING);
  endfunction

endpackage

// File: rtl/weight_pingpong_buffer_if.sv
// Loader/PE-side signal bundle for the ping-pong weight buffer.
// rd_replay exists only when WPB_REPLAY_EN is defined.
interface weight_pingpong_buffer_if
  import weight_buf_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) ();

  // Handshakes: a write transfers on a cycle where wr_valid & wr_ready at posedge;
  // the master may hold wr_valid/wr_data while wr_ready is low (that sets err_ovf and
  // drops the word). A read transfers when rd_en & rd_avail; rd_valid/rd_data/rd_last
  // follow one cycle later. rd_en without rd_avail is a no-op.
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_avail;
  logic              rd_en;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              wr_bank;
  logic              rd_bank;
  logic              err_ovf;
`ifdef WPB_REPLAY_EN
  logic              rd_replay;
`endif

  modport master (
    output wr_valid, wr_data, rd_en,
`ifdef WPB_REPLAY_EN
    output rd_replay,
`endif
    input  wr_ready, rd_avail, rd_valid, rd_data, rd_last, wr_bank, rd_bank, err_ovf
  );

  modport slave (
    input  wr_valid, wr_data, rd_en,
`ifdef WPB_REPLAY_EN
    input  rd_replay,
`endif
    output wr_ready, rd_avail, rd_valid, rd_data, rd_last, wr_bank, rd_bank, err_ovf
  );

endinterface

// File: rtl/weight_bank.sv
// One DEPTH x DATA_W weight bank: synchronous write, registered read.
// Only the read register is reset; the array contents survive reset.
module weight_bank
  import weight_buf_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store: one bank fills while the other streams to the PE array.
// Optional feature WPB_REPLAY_EN: rd_replay on the last read keeps the bank FULL for another pass.
module weight_pingpong_buffer
  import weight_buf_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  weight_pingpong_buffer_if.slave bus,
  output bank_state_t [1:0]      dbg_state_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bank_state_t [1:0] state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;

  logic              rd_sel_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              err_ovf_q;

  logic              wr_ready;
  logic              rd_avail;
  logic              wr_fire;
  logic              rd_fire;
  logic              wr_final;
  logic              rd_final;
  logic              rd_keep;

  logic [1:0]        bank_we;
  logic [1:0]        bank_re;
  logic [DATA_W-1:0] bank_rdata [2];

  assign wr_ready = bank_writable(state_q[wr_bank_q]);
  assign rd_avail = bank_readable(state_q[rd_bank_q]);
  assign wr_fire  = bus.wr_valid & wr_ready;
  assign rd_fire  = bus.rd_en & rd_avail;
  assign wr_final = wr_fire && (wptr_q == LAST_ADDR);
  assign rd_final = rd_fire && (rptr_q == LAST_ADDR);

`ifdef WPB_REPLAY_EN
  assign rd_keep = rd_final & bus.rd_replay;
`else
  assign rd_keep = 1'b0;
`endif

  // The write bank is always EMPTY/FILLING and the read bank FULL/DRAINING, so
  // the two updates below never land on the same bank in one cycle.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;

    if (wr_fire) begin
      wptr_d = wptr_q + ADDR_W'(1);
      if (wr_final) begin
        state_d[wr_bank_q] = FULL;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
      end
    end

    if (rd_fire) begin
      rptr_d = rptr_q + ADDR_W'(1);
      if (!rd_final) begin
        state_d[rd_bank_q] = DRAINING;
      end else if (rd_keep) begin
        state_d[rd_bank_q] = FULL;
      end else begin
        state_d[rd_bank_q] = EMPTY;
        rd_bank_d          = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  // rd_sel_q remembers which bank produced the word now sitting in its read register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_last_q  <= rd_final;
      err_ovf_q  <= err_ovf_q | (bus.wr_valid & ~wr_ready);
      if (rd_fire) begin
        rd_sel_q <= rd_bank_q;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bank_we[g] = wr_fire && (wr_bank_q == 1'(g));
    assign bank_re[g] = rd_fire && (rd_bank_q == 1'(g));

    weight_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (bank_we[g]),
      .waddr_i (wptr_q),
      .wdata_i (bus.wr_data),
      .re_i    (bank_re[g]),
      .raddr_i (rptr_q),
      .rdata_o (bank_rdata[g])
    );
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_avail = rd_avail;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bank_rdata[rd_sel_q];
  assign bus.rd_last  = rd_last_q;
  assign bus.wr_bank  = wr_bank_q;
  assign bus.rd_bank  = rd_bank_q;
  assign bus.err_ovf  = err_ovf_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Directed bench for weight_pingpong_buffer at DEPTH=4; the replay pass runs when WPB_REPLAY_EN is defined.
module tb_weight_pingpong_buffer;
  import weight_buf_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bank_state_t [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];

  weight_pingpong_buffer_if #(.DATA_W(DATA_W)) bus ();

  weight_pingpong_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic fill_bank(input logic [DATA_W-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + DATA_W'(i);
      exp_q.push_back(base + DATA_W'(i));
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  // scoreboard: each observed word must match the oldest expected word
  task automatic check_rd(input string tag, input logic exp_last);
    logic [DATA_W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rd_data),  32'(e));
    check({tag, "_last"},  32'(bus.rd_last),  32'(exp_last));
  endtask

  task automatic drain_bank(input string tag);
    bus.rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check_rd(tag, i == DEPTH - 1);
    end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    // 1. reset with wr_valid held high
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h1234;
    bus.rd_en    = 1'b0;
`ifdef WPB_REPLAY_EN
    bus.rd_replay = 1'b0;
`endif
    rst = 1'b0;
    tick();
    tick();
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_rd_avail", 32'(bus.rd_avail), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_err_ovf",  32'(bus.err_ovf),  32'd0);
    check("rst_rd_data",  32'(bus.rd_data),  32'd0);
    check("rst_rd_last",  32'(bus.rd_last),  32'd0);
    check("rst_wr_bank",  32'(bus.wr_bank),  32'd0);
    check("rst_rd_bank",  32'(bus.rd_bank),  32'd0);
    tick();
    check("rst_no_write", 32'(dbg_state[0]), 32'(EMPTY));

    // 2. fill then drain bank0
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h0011 * DATA_W'(i + 1);
      exp_q.push_back(16'h0011 * DATA_W'(i + 1));
      tick();
      if (i == DEPTH - 2) check("t2_avail_partial", 32'(bus.rd_avail), 32'd0);
    end
    bus.wr_valid = 1'b0;
    check("t2_avail_full", 32'(bus.rd_avail), 32'd1);
    check("t2_wr_bank",    32'(bus.wr_bank),  32'd1);
    check("t2_state0",     32'(dbg_state[0]), 32'(FULL));
    drain_bank("t2_rd");
    check("t2_rd_bank",    32'(bus.rd_bank),  32'd1);
    check("t2_avail_done", 32'(bus.rd_avail), 32'd0);
    tick();
    check("t2_valid_idle", 32'(bus.rd_valid), 32'd0);

    // 3 + 5. ping-pong overlap, ending in simultaneous final write and final read
    do_reset();
    fill_bank(16'h0501);
    bus.rd_en    = 1'b1;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_data = 16'h0100 + DATA_W'(i);
      exp_q.push_back(16'h0100 + DATA_W'(i));
      tick();
      check_rd("t3_rd_bank0", i == DEPTH - 1);
    end
    bus.wr_valid = 1'b0;
    check("t5_rd_bank",  32'(bus.rd_bank),  32'd1);
    check("t5_wr_bank",  32'(bus.wr_bank),  32'd0);
    check("t5_rd_avail", 32'(bus.rd_avail), 32'd1);
    check("t5_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("t5_state1",   32'(dbg_state[1]), 32'(FULL));
    check("t5_state0",   32'(dbg_state[0]), 32'(EMPTY));
    drain_bank("t3_rd_bank1");
    check("t3_rd_bank_back", 32'(bus.rd_bank),  32'd0);
    check("t3_avail_done",   32'(bus.rd_avail), 32'd0);

    // 4. backpressure and overflow
    fill_bank(16'h1000);
    fill_bank(16'h2000);
    check("t4_wr_ready_full", 32'(bus.wr_ready), 32'd0);
    check("t4_err_before",    32'(bus.err_ovf),  32'd0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hDEAD;
    tick();
    bus.wr_valid = 1'b0;
    check("t4_err_ovf",       32'(bus.err_ovf),  32'd1);
    check("t4_wr_ready_hold", 32'(bus.wr_ready), 32'd0);
    bus.rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check_rd("t4_rd_bank0", i == DEPTH - 1);
      if (i == DEPTH - 2) check("t4_wr_ready_late", 32'(bus.wr_ready), 32'd0);
    end
    check("t4_wr_ready_back", 32'(bus.wr_ready), 32'd1);
    drain_bank("t4_rd_bank1");
    check("t4_err_sticky", 32'(bus.err_ovf),  32'd1);
    check("t4_avail_done", 32'(bus.rd_avail), 32'd0);

    // 6. reset after 2 of 4 reads, then a clean fill/drain with a gap
    fill_bank(16'h0030);
    bus.rd_en = 1'b1;
    tick();
    check_rd("t6_pre0", 1'b0);
    tick();
    check_rd("t6_pre1", 1'b0);
    bus.rd_en = 1'b0;
    do_reset();
    check("t6_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("t6_rd_avail", 32'(bus.rd_avail), 32'd0);
    check("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("t6_err_ovf",  32'(bus.err_ovf),  32'd0);
    check("t6_rd_last",  32'(bus.rd_last),  32'd0);
    check("t6_rd_data",  32'(bus.rd_data),  32'd0);
    check("t6_wr_bank",  32'(bus.wr_bank),  32'd0);
    check("t6_rd_bank",  32'(bus.rd_bank),  32'd0);
    check("t6_state0",   32'(dbg_state[0]), 32'(EMPTY));
    fill_bank(16'h00A0);
    bus.rd_en = 1'b1;
    tick();
    check_rd("t6_rd", 1'b0);
    tick();
    check_rd("t6_rd", 1'b0);
    bus.rd_en = 1'b0;
    tick();
    check("t6_gap_valid", 32'(bus.rd_valid), 32'd0);
    bus.rd_en = 1'b1;
    tick();
    check_rd("t6_rd", 1'b0);
    tick();
    check_rd("t6_rd", 1'b1);
    tick();
    check("t6_ignored_valid", 32'(bus.rd_valid), 32'd0);
    bus.rd_en = 1'b0;
    check("t6_rd_bank_end", 32'(bus.rd_bank), 32'd1);

`ifdef WPB_REPLAY_EN
    // replay: bank1 read twice without changing rd_bank
    fill_bank(16'h0E00);
    bus.rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_replay = (i == DEPTH - 1);
      tick();
      check_rd("rp_pass1", i == DEPTH - 1);
    end
    bus.rd_replay = 1'b0;
    check("rp_rd_bank_kept", 32'(bus.rd_bank),  32'd1);
    check("rp_avail_kept",   32'(bus.rd_avail), 32'd1);
    check("rp_state1",       32'(dbg_state[1]), 32'(FULL));
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(16'h0E00 + DATA_W'(i));
    drain_bank("rp_pass2");
    check("rp_rd_bank_next", 32'(bus.rd_bank),  32'd0);
    check("rp_avail_done",   32'(bus.rd_avail), 32'd0);
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
